// File: rtl/usb_rx_pkt_sequencer_if.sv
// Bit-level bundle between the unstuffer, the CRC16 datapath and the
// receive packet sequencer.
interface usb_rx_pkt_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             sync_seen;
  logic             bit_valid;
  logic             in_bit;
  logic             eop;
  logic [15:0]      crc_residue;
  logic             crc_clr;
  logic             crc_en;
  logic [7:0]       pid;
  logic [CNT_W-1:0] data_bit_cnt;
  logic             busy;
  logic             pkt_done;
  logic             pkt_ok;
  logic [2:0]       err_code;

  modport master (
    output sync_seen,
    output bit_valid,
    output in_bit,
    output eop,
    output crc_residue,
    input  crc_clr,
    input  crc_en,
    input  pid,
    input  data_bit_cnt,
    input  busy,
    input  pkt_done,
    input  pkt_ok,
    input  err_code
  );

  modport slave (
    input  sync_seen,
    input  bit_valid,
    input  in_bit,
    input  eop,
    input  crc_residue,
    output crc_clr,
    output crc_en,
    output pid,
    output data_bit_cnt,
    output busy,
    output pkt_done,
    output pkt_ok,
    output err_code
  );
endinterface

// File: rtl/usb_rx_pkt_sequencer.sv
// USB receive packet sequencer: PID capture, data/handshake
// classification, CRC16 gating and one status strobe per packet.
module usb_rx_pkt_sequencer #(
  parameter int MAX_DATA_BITS = 80,
  parameter int MIN_DATA_BITS = 16,
  parameter int TIMEOUT       = 32,
  parameter int CNT_W         = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  usb_rx_pkt_sequencer_if.slave bus
);

  localparam int TM_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] C_SAT =
    CNT_W'(MAX_DATA_BITS + 1);
  localparam logic [CNT_W-1:0] C_MIN =
    CNT_W'(MIN_DATA_BITS);
  localparam logic [CNT_W-1:0] C_MAX =
    CNT_W'(MAX_DATA_BITS);
  localparam logic [TM_W-1:0] C_TMO =
    TM_W'(TIMEOUT - 1);

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_PID  = 3'd1;
  localparam logic [2:0] E_CRC  = 3'd2;
  localparam logic [2:0] E_LEN  = 3'd3;
  localparam logic [2:0] E_TMO  = 3'd4;
  localparam logic [2:0] E_ABT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_HS,
    S_CHECK
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [7:0]       r_pid;
  logic [2:0]       r_pid_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [TM_W-1:0]  r_timer;
  logic [2:0]       r_err;
  logic             r_is_data;
  logic             r_busy;
  logic             r_done;
  logic             r_ok;
  logic [2:0]       r_code;

  logic [7:0] w_pid_shift;
  logic       w_pid_last;
  logic       w_pid_chk;
  logic       w_is_dpid;
  logic       w_is_hpid;
  logic       w_tmo;
  logic       w_len_bad;
  logic [2:0] w_err_set;
  logic [2:0] w_fin;

  assign w_pid_shift = {bus.in_bit, r_pid[7:1]};
  assign w_pid_last  = (r_pid_cnt == 3'd7);
  assign w_pid_chk   =
    (w_pid_shift[3:0] == ~w_pid_shift[7:4]);
  assign w_is_dpid   = (w_pid_shift[3:0] == 4'b0011)
                    || (w_pid_shift[3:0] == 4'b1011);
  assign w_is_hpid   = (w_pid_shift[3:0] == 4'b0010)
                    || (w_pid_shift[3:0] == 4'b1010);
  assign w_tmo = !bus.bit_valid && !bus.eop
              && (r_timer == C_TMO);

  assign w_len_bad = (r_cnt < C_MIN) || (r_cnt > C_MAX)
                  || (r_cnt[2:0] != 3'd0);

  // Earliest recorded cause wins over the end-of-packet checks
  always_comb begin
    w_fin = E_NONE;
    if (r_err != E_NONE)
      w_fin = r_err;
    else if (r_is_data && w_len_bad)
      w_fin = E_LEN;
    else if (r_is_data && bus.crc_residue != 16'h800D)
      w_fin = E_CRC;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_err_set = E_NONE;
    unique case (r_state)
      S_IDLE: begin
        if (bus.sync_seen)
          w_nxt = S_PID;
      end
      S_PID: begin
        if (bus.sync_seen) begin
          w_nxt     = S_CHECK;
          w_err_set = E_ABT;
        end else begin
          if (bus.bit_valid && w_pid_last) begin
            if (!w_pid_chk) begin
              w_nxt     = S_CHECK;
              w_err_set = E_PID;
            end else if (w_is_dpid) begin
              w_nxt = S_DATA;
            end else if (w_is_hpid) begin
              w_nxt = S_HS;
            end else begin
              w_nxt     = S_CHECK;
              w_err_set = E_PID;
            end
          end
          if (bus.eop) begin
            w_nxt = S_CHECK;
            if (!(bus.bit_valid && w_pid_last))
              w_err_set = E_LEN;
          end else if (w_tmo) begin
            w_nxt     = S_CHECK;
            w_err_set = E_TMO;
          end
        end
      end
      S_DATA, S_HS: begin
        if (bus.sync_seen) begin
          w_nxt     = S_CHECK;
          w_err_set = E_ABT;
        end else begin
          if (r_state == S_HS && bus.bit_valid)
            w_err_set = E_LEN;
          if (bus.eop) begin
            w_nxt = S_CHECK;
          end else if (w_tmo) begin
            w_nxt     = S_CHECK;
            w_err_set = E_TMO;
          end
        end
      end
      S_CHECK: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.crc_clr = (r_state == S_IDLE) && bus.sync_seen;
    bus.crc_en  = (r_state == S_DATA) && bus.bit_valid;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pid     <= '0;
      r_pid_cnt <= '0;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_err     <= E_NONE;
      r_is_data <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_code    <= E_NONE;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_nxt != S_IDLE);
      if (w_err_set != E_NONE && r_err == E_NONE)
        r_err <= w_err_set;
      unique case (r_state)
        S_IDLE: begin
          if (bus.sync_seen) begin
            r_pid     <= '0;
            r_pid_cnt <= '0;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_err     <= E_NONE;
            r_is_data <= 1'b0;
          end
        end
        S_PID, S_DATA, S_HS: begin
          if (bus.bit_valid || bus.eop)
            r_timer <= '0;
          else
            r_timer <= r_timer + TM_W'(1);
          if (bus.bit_valid && !bus.sync_seen) begin
            if (r_state == S_PID) begin
              r_pid     <= w_pid_shift;
              r_pid_cnt <= r_pid_cnt + 3'd1;
              r_is_data <= w_pid_last && w_pid_chk
                        && w_is_dpid;
            end
            if (r_state == S_DATA && r_cnt != C_SAT)
              r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          r_done <= 1'b1;
          r_ok   <= (w_fin == E_NONE);
          r_code <= w_fin;
        end
        default: ;
      endcase
    end
  end

  assign bus.pid          = r_pid;
  assign bus.data_bit_cnt = r_cnt;
  assign bus.busy         = r_busy;
  assign bus.pkt_done     = r_done;
  assign bus.pkt_ok       = r_ok;
  assign bus.err_code     = r_code;

endmodule
